// File: rtl/line_buffer_ntap.sv
// Vertical N-tap line buffer: NUM_TAPS-1 previous lines held in circular RAM slots, all taps registered.
// Optional macro LINE_BUFFER_NTAP_ZERO_PAD_EN zeroes taps for lines not yet written in the current frame.
module line_buffer_ntap #(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_LINE_WORDS = 1280,
  parameter int NUM_TAPS       = 3,
  localparam int ADDR_WIDTH    = $clog2(MAX_LINE_WORDS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sof,
  input  logic [ADDR_WIDTH-1:0]          line_words,
  input  logic                           en,
  input  logic [DATA_WIDTH-1:0]          din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] dout_taps,
  output logic                           dout_valid,
  output logic                           dout_padded_valid,
  output logic                           dout_eol
);

  localparam int SLOTS     = NUM_TAPS - 1;
  localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int IDX_W     = (MAX_LINE_WORDS > 1) ? $clog2(MAX_LINE_WORDS) : 1;
  localparam int LINE_W    = $clog2(NUM_TAPS);
  localparam int PAD_LINES = (NUM_TAPS - 1) / 2;

  logic [DATA_WIDTH-1:0] mem [SLOTS][MAX_LINE_WORDS];
  logic [DATA_WIDTH-1:0] taps_r [NUM_TAPS];

  logic [ADDR_WIDTH-1:0] col_r;
  logic [ADDR_WIDTH-1:0] lw_r;
  logic [LINE_W-1:0]     line_r;
  logic [SLOT_W-1:0]     slot_r;
  logic                  valid_r;
  logic                  padded_r;
  logic                  eol_r;

  logic                  accept_s;
  logic [ADDR_WIDTH-1:0] lw_in_s;
  logic [ADDR_WIDTH-1:0] cur_col_s;
  logic [ADDR_WIDTH-1:0] cur_lw_s;
  logic [LINE_W-1:0]     cur_line_s;
  logic [SLOT_W-1:0]     cur_slot_s;
  logic                  wrap_s;
  logic [ADDR_WIDTH-1:0] next_col_s;
  logic [LINE_W-1:0]     next_line_s;
  logic [SLOT_W-1:0]     next_slot_s;

  // Slot holding the line k rows above the line being written into slot s.
  function automatic logic [SLOT_W-1:0] tap_slot(input logic [SLOT_W-1:0] s, input int k);
    int t;
    t = (int'(s) + SLOTS - k) % SLOTS;
    return SLOT_W'(t);
  endfunction

  assign accept_s = en & ~rst;

  // Position of the pixel on din; a start of frame forces column 0, line 0, slot 0.
  always_comb begin
    lw_in_s = line_words;
    if ((line_words == '0) || (line_words > ADDR_WIDTH'(MAX_LINE_WORDS))) begin
      lw_in_s = ADDR_WIDTH'(MAX_LINE_WORDS);
    end else begin
      lw_in_s = line_words;
    end
    if (sof) begin
      cur_col_s  = '0;
      cur_line_s = '0;
      cur_slot_s = '0;
      cur_lw_s   = lw_in_s;
    end else begin
      cur_col_s  = col_r;
      cur_line_s = line_r;
      cur_slot_s = slot_r;
      cur_lw_s   = lw_r;
    end
  end

  // Successor column, line count and write slot after accepting the current pixel.
  always_comb begin
    wrap_s      = (cur_col_s == (cur_lw_s - ADDR_WIDTH'(1)));
    next_col_s  = cur_col_s + ADDR_WIDTH'(1);
    next_line_s = cur_line_s;
    next_slot_s = cur_slot_s;
    if (wrap_s) begin
      next_col_s = '0;
      if (cur_line_s != LINE_W'(SLOTS)) begin
        next_line_s = cur_line_s + LINE_W'(1);
      end else begin
        next_line_s = cur_line_s;
      end
      if (cur_slot_s == SLOT_W'(SLOTS - 1)) begin
        next_slot_s = '0;
      end else begin
        next_slot_s = cur_slot_s + SLOT_W'(1);
      end
    end else begin
      next_col_s = cur_col_s + ADDR_WIDTH'(1);
    end
  end

  // Position counters and latched line length.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r  <= '0;
      line_r <= '0;
      slot_r <= '0;
      lw_r   <= ADDR_WIDTH'(MAX_LINE_WORDS);
    end else begin
      if (sof) begin
        lw_r <= lw_in_s;
      end
      if (en) begin
        col_r  <= next_col_s;
        line_r <= next_line_s;
        slot_r <= next_slot_s;
      end
    end
  end

  // Line storage write; reads elsewhere see the old word at the same address.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem[cur_slot_s][cur_col_s[IDX_W-1:0]] <= din;
    end
  end

  // Registered taps and flags, updated only on accepted pixels so they hold while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        taps_r[k] <= '0;
      end
      valid_r  <= 1'b0;
      padded_r <= 1'b0;
      eol_r    <= 1'b0;
    end else if (en) begin
      taps_r[0] <= din;
      for (int k = 1; k < NUM_TAPS; k++) begin
`ifdef LINE_BUFFER_NTAP_ZERO_PAD_EN
        if (k > int'(cur_line_s)) begin
          taps_r[k] <= '0;
        end else begin
          taps_r[k] <= mem[tap_slot(cur_slot_s, k)][cur_col_s[IDX_W-1:0]];
        end
`else
        taps_r[k] <= mem[tap_slot(cur_slot_s, k)][cur_col_s[IDX_W-1:0]];
`endif
      end
      valid_r  <= (cur_line_s >= LINE_W'(SLOTS));
      padded_r <= (cur_line_s >= LINE_W'(PAD_LINES));
      eol_r    <= wrap_s;
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_taps
    assign dout_taps[g*DATA_WIDTH +: DATA_WIDTH] = taps_r[g];
  end

  assign dout_valid        = valid_r;
  assign dout_padded_valid = padded_r;
  assign dout_eol          = eol_r;

endmodule

// File: tb/tb_line_buffer_ntap.sv
// Scoreboard bench for line_buffer_ntap (NUM_TAPS=3, MAX_LINE_WORDS=8); directed frames,
// expected taps taken from a per-frame pixel history, hand-computed stale taps for the second frame.
module tb_line_buffer_ntap;

  localparam int W    = 8;
  localparam int N    = 3;
  localparam int MAXW = 8;
  localparam int AW   = 4;

  typedef struct {
    logic [N*W-1:0] taps;
    logic [N*W-1:0] mask;
    logic           v;
    logic           p;
    logic           e;
  } exp_t;

  logic            clk;
  logic            rst;
  logic            sof;
  logic [AW-1:0]   line_words;
  logic            en;
  logic [W-1:0]    din;
  logic [N*W-1:0]  dout_taps;
  logic            dout_valid;
  logic            dout_padded_valid;
  logic            dout_eol;

  exp_t sb[$];
  exp_t last_exp;
  int   n_checks;
  int   n_fail;
  int   m_lw, m_col, m_L, m_fl;
  int   frame [0:15][0:7];
  logic mon_acc, mon_rst;

  line_buffer_ntap #(.DATA_WIDTH(W), .MAX_LINE_WORDS(MAXW), .NUM_TAPS(N)) dut (
    .clk(clk), .rst(rst), .sof(sof), .line_words(line_words), .en(en), .din(din),
    .dout_taps(dout_taps), .dout_valid(dout_valid),
    .dout_padded_valid(dout_padded_valid), .dout_eol(dout_eol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int eff_lw(input int lw);
    return ((lw == 0) || (lw > MAXW)) ? MAXW : lw;
  endfunction

  task automatic cmp(input string nm, input exp_t x);
    n_checks++;
    if ((dout_taps & x.mask) !== (x.taps & x.mask)) begin
      n_fail++;
      $display("FAIL %s_taps: got %h want %h (mask %h) at %0t", nm, dout_taps, x.taps, x.mask, $time);
    end
    n_checks++;
    if ({dout_valid, dout_padded_valid, dout_eol} !== {x.v, x.p, x.e}) begin
      n_fail++;
      $display("FAIL %s_flags: got v/p/e=%b%b%b want %b%b%b at %0t", nm,
               dout_valid, dout_padded_valid, dout_eol, x.v, x.p, x.e, $time);
    end
  endtask

  // Expected response for one accepted pixel; s1/s2 give stale tap values (-1 = unchecked).
  task automatic model_push(input logic s, input int lw, input int d, input int s1, input int s2);
    exp_t x;
    int   st [3];
    if (s) begin
      m_fl = 0; m_col = 0; m_L = 0; m_lw = eff_lw(lw);
    end
    st[0] = -1; st[1] = s1; st[2] = s2;
    x.taps = '0;
    x.mask = '0;
    x.taps[W-1:0] = W'(d);
    x.mask[W-1:0] = {W{1'b1}};
    for (int k = 1; k < N; k++) begin
      if (k <= m_L) begin
        x.taps[k*W +: W] = W'(frame[m_fl-k][m_col]);
        x.mask[k*W +: W] = {W{1'b1}};
      end else begin
`ifdef LINE_BUFFER_NTAP_ZERO_PAD_EN
        x.taps[k*W +: W] = {W{1'b0}};
        x.mask[k*W +: W] = {W{1'b1}};
`else
        if (st[k] >= 0) begin
          x.taps[k*W +: W] = W'(st[k]);
          x.mask[k*W +: W] = {W{1'b1}};
        end
`endif
      end
    end
    x.v = (m_L >= 2);
    x.p = (m_L >= 1);
    x.e = (m_col == m_lw - 1);
    sb.push_back(x);
    frame[m_fl][m_col] = d;
    if (x.e) begin
      m_col = 0;
      if (m_fl < 15) m_fl++;
      if (m_L < 2) m_L++;
    end else begin
      m_col++;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic e, input int lw, input int d,
                     input int s1 = -1, input int s2 = -1);
    @(negedge clk);
    rst = r; sof = s; en = e; line_words = AW'(lw); din = W'(d);
    if (r) begin
      m_lw = MAXW; m_col = 0; m_L = 0; m_fl = 0;
    end else if (e) begin
      model_push(s, lw, d, s1, s2);
    end else if (s) begin
      m_lw = eff_lw(lw);
    end
  endtask

  // Monitor: check reset state, popped expectations on accepted cycles, held outputs otherwise.
  always @(posedge clk) begin
    mon_acc = en && !rst;
    mon_rst = rst;
    #1;
    if (mon_rst) begin
      last_exp.taps = '0;
      last_exp.mask = '1;
      last_exp.v = 1'b0; last_exp.p = 1'b0; last_exp.e = 1'b0;
      cmp("reset", last_exp);
    end else if (mon_acc) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got taps %h with empty scoreboard at %0t", dout_taps, $time);
      end else begin
        last_exp = sb.pop_front();
        cmp("out", last_exp);
      end
    end else begin
      cmp("hold", last_exp);
    end
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_lw = MAXW; m_col = 0; m_L = 0; m_fl = 0;
    rst = 1'b1; sof = 1'b0; en = 1'b0; line_words = '0; din = '0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4, 0);
    // Frame 1: 3 lines of 4 continuous pixels 1..12
    for (int i = 0; i < 12; i++) cyc(0, i == 0, 1, 4, i + 1);
    // Frame 2: en toggled, first-line taps show previous frame's RAM contents
    for (int i = 0; i < 12; i++) begin
      int ln, c;
      ln = i / 4; c = i % 4;
      cyc(0, i == 0, 1, 4, 21 + i, (ln == 0) ? 5 + c : -1,
          (ln == 0) ? 9 + c : ((ln == 1) ? 5 + c : -1));
      cyc(0, 0, 0, 4, 0);
    end
    // Frame 3: sof arrives at column 2 of line 3
    for (int i = 0; i < 14; i++) cyc(0, i == 0, 1, 4, 41 + i);
    cyc(0, 1, 1, 4, 60);
    for (int i = 1; i < 4; i++) cyc(0, 0, 1, 4, 60 + i);
    // sof with en low only latches a new length of 3
    cyc(0, 1, 0, 3, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 7, 64 + i);
    // line_words=0 falls back to MAX_LINE_WORDS=8
    for (int i = 0; i < 19; i++) cyc(0, i == 0, 1, 0, 100 + i);
    // Reset concurrent with en and sof mid-line
    cyc(1, 1, 1, 4, 77);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 4, 81 + i);
    cyc(0, 0, 0, 4, 0);
    cyc(0, 0, 0, 4, 0);
    cyc(0, 0, 0, 4, 0);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
